// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : frame-format types and constants shared by uart_tx/rx |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int TICKS_PER_BIT = 16;

  localparam int STOP_1   = 1;
  localparam int STOP_2   = 2;
  localparam int STOP_1P5 = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Unknown stop codes fall back to a single stop bit.
  function automatic int stop_ticks(input int code);
    case (code)
      STOP_2:   return 2 * TICKS_PER_BIT;
      STOP_1P5: return (3 * TICKS_PER_BIT) / 2;
      default:  return TICKS_PER_BIT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// +------------------------------------------------------------------+
// | uart_tx_if : valid/ready word handshake into the UART transmitter |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
`default_nettype none

interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  in_vld;
  logic                  in_rdy;

  modport master (
    output data_in,
    output in_vld,
    input  in_rdy
  );

  modport slave (
    input  data_in,
    input  in_vld,
    output in_rdy
  );

endinterface

`default_nettype wire

// File: rtl/uart_bit_tick.sv
// +------------------------------------------------------------------+
// | uart_bit_tick : 16x-oversample tick counter with last-tick strobe |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

module uart_bit_tick
  import uart_pkg::*;
(
  input  wire  clk,
  input  wire  rst_n,
  input  wire  clr,
  output logic tick15
);

  localparam int TICK_W = $clog2(TICKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

  logic [TICK_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick15 = (r_cnt == TICK_LAST) && !clr;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// +------------------------------------------------------------------+
// | uart_tx : serialises handshake words as start/data/parity/stop    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ON  = 1,
  parameter int PARITY_ODD = 1,
  parameter int STOP_BIT   = 1
) (
  input  wire        clk,
  input  wire        rst_n,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [4:0]    STOP_LAST = 5'(stop_ticks(STOP_BIT) - 1);

  uart_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bit_cnt;
  logic [4:0]            r_stop_cnt;
  logic                  r_parity;
  logic                  w_tick15;
  logic                  w_tick_clr;

  // The tick counter wraps naturally at every START/DATA/PARITY boundary;
  // it only needs holding at zero while idle or timing the stop period.
  assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_STOP);
  assign bus.in_rdy = (r_state == ST_IDLE);

  uart_bit_tick u_bit_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_tick_clr),
    .tick15 (w_tick15)
  );

  // tx is driven from the state held before each edge, so the line lags the
  // state by one clock and falls on the edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_parity   <= 1'b0;
      tx         <= 1'b1;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          tx         <= 1'b1;
          r_bit_cnt  <= '0;
          r_stop_cnt <= '0;
          if (bus.in_vld) begin
            r_shreg  <= bus.data_in;
            r_parity <= (PARITY_ODD != 0) ? ~^bus.data_in : ^bus.data_in;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          tx <= 1'b0;
          if (w_tick15) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx <= r_shreg[0];
          if (w_tick15) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          tx <= r_parity;
          if (w_tick15) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (r_stop_cnt == STOP_LAST) begin
            r_stop_cnt <= '0;
            r_state    <= ST_IDLE;
            done       <= 1'b1;
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
